// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

    localparam int unsigned DIV_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    localparam logic [DIV_W-1:0] BAUD_230400_DIV = 16'd217;

    // Parity bit for the masked data bits; odd makes the total ones count odd.
    function automatic logic parity_bit(input logic [7:0] data,
                                        input logic [7:0] mask,
                                        input int unsigned mode);
        logic w_xor;
        w_xor = ^(data & mask);
        return (mode == PARITY_ODD) ? ~w_xor : w_xor;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period down-counter: single-cycle tick every i_div cycles, held at reload while restarting.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_restart,
    output logic             o_bit_tick_c
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == '0)) begin
            r_cnt <= i_div - DIV_W'(1);
        end else begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    assign o_bit_tick_c = !i_restart && (r_cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// Asynchronous serial transmitter: one frame per rising edge of tx_ready, runtime bit divisor.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = PARITY_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [DIV_W-1:0] clock_div,
    input  logic [7:0]       tx_data,
    input  logic             tx_ready,
    output logic             tx,
    output logic             tx_done
);

    localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t      r_state;
    logic [7:0]       r_shift;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_bit_cnt;
    logic             r_stop_cnt;
    logic             r_par;
    logic             r_tx;
    logic             r_tx_done;
    logic             r_tx_ready_q;

    logic             w_start;
    logic             w_restart;
    logic             w_bit_tick;
    logic [DIV_W-1:0] w_div_load;
    logic [DIV_W-1:0] w_div;

    assign w_start    = tx_ready && !r_tx_ready_q && (r_state == ST_IDLE);
    assign w_div_load = (clock_div == '0) ? DIV_W'(1) : clock_div;
    // The counter must load the new divisor on the accepting edge itself.
    assign w_div      = w_start ? w_div_load : r_div;
    assign w_restart  = (r_state == ST_IDLE);

    uart_baud_gen u_baud (
        .i_clk        (CLOCK_50),
        .i_rst_n      (reset),
        .i_div        (w_div),
        .i_restart    (w_restart),
        .o_bit_tick_c (w_bit_tick)
    );

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_div        <= DIV_W'(1);
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_par        <= 1'b0;
            r_tx         <= 1'b1;
            r_tx_done    <= 1'b1;
            r_tx_ready_q <= 1'b1;
        end else begin
            r_tx_ready_q <= tx_ready;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_shift   <= tx_data;
                        r_div     <= w_div_load;
                        r_par     <= parity_bit(tx_data, DATA_MASK, PARITY);
                        r_tx      <= 1'b0;
                        r_tx_done <= 1'b0;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_tick) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            if (PARITY != PARITY_NONE) begin
                                r_tx    <= r_par;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_stop_cnt <= 1'b0;
                                r_state    <= ST_STOP;
                            end
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_tick) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_bit_tick) begin
                        if (r_stop_cnt == LAST_STOP) begin
                            r_tx_done <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx      <= 1'b1;
                    r_tx_done <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: frame shapes, parity/stop variants, request edges, reset abort.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int RX_DIV = 217;

    logic        CLOCK_50;
    logic        reset;
    logic [15:0] clock_div;
    logic [7:0]  tx_data;
    logic        rdy0, rdy_odd, rdy_ev;
    logic        tx0, done0, tx_odd, done_odd, tx_ev, done_ev;

    int          n_vec;
    int          n_err;

    logic        rx_en;
    logic [7:0]  rx_byte;
    int          rx_frame_err;
    logic [7:0]  rx_q[$];

    uart_tx u_dut (
        .CLOCK_50 (CLOCK_50), .reset (reset), .clock_div (clock_div),
        .tx_data  (tx_data),  .tx_ready (rdy0), .tx (tx0), .tx_done (done0)
    );

    uart_tx #(.PARITY(PARITY_ODD)) u_odd (
        .CLOCK_50 (CLOCK_50), .reset (reset), .clock_div (clock_div),
        .tx_data  (tx_data),  .tx_ready (rdy_odd), .tx (tx_odd), .tx_done (done_odd)
    );

    uart_tx #(.PARITY(PARITY_EVEN), .STOP_BITS(2)) u_even (
        .CLOCK_50 (CLOCK_50), .reset (reset), .clock_div (clock_div),
        .tx_data  (tx_data),  .tx_ready (rdy_ev), .tx (tx_ev), .tx_done (done_ev)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Receiver model: mid-bit sampling of tx0 at 217 cycles per bit.
    always begin
        @(negedge CLOCK_50);
        if (rx_en && tx0 === 1'b0) begin
            repeat (RX_DIV / 2) @(negedge CLOCK_50);
            if (tx0 !== 1'b0) rx_frame_err++;
            for (int i = 0; i < 8; i++) begin
                repeat (RX_DIV) @(negedge CLOCK_50);
                rx_byte[i] = tx0;
            end
            repeat (RX_DIV) @(negedge CLOCK_50);
            if (tx0 !== 1'b1) rx_frame_err++;
            rx_q.push_back(rx_byte);
        end
    end

    task automatic test_reset;
        repeat (2) @(negedge CLOCK_50);
        n_vec++; if (tx0 !== 1'b1)      begin n_err++; $display("FAIL reset_tx0 got=%b exp=1", tx0); end
        n_vec++; if (done0 !== 1'b1)    begin n_err++; $display("FAIL reset_done0 got=%b exp=1", done0); end
        n_vec++; if (tx_odd !== 1'b1)   begin n_err++; $display("FAIL reset_tx_odd got=%b exp=1", tx_odd); end
        n_vec++; if (done_odd !== 1'b1) begin n_err++; $display("FAIL reset_done_odd got=%b exp=1", done_odd); end
        n_vec++; if (tx_ev !== 1'b1)    begin n_err++; $display("FAIL reset_tx_ev got=%b exp=1", tx_ev); end
        n_vec++; if (done_ev !== 1'b1)  begin n_err++; $display("FAIL reset_done_ev got=%b exp=1", done_ev); end
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        n_vec++; if (tx0 !== 1'b1 || done0 !== 1'b1)
            begin n_err++; $display("FAIL idle_after_reset got=%b%b exp=11", tx0, done0); end
    endtask

    task automatic test_basic;
        logic [9:0] exp_bits;
        logic       exp_tx;
        exp_bits  = 10'b1_01010101_0;
        clock_div = 16'd4; tx_data = 8'h55; rdy0 = 1'b1;
        @(negedge CLOCK_50);
        rdy0 = 1'b0;
        for (int k = 0; k <= 44; k++) begin
            exp_tx = (k < 40) ? exp_bits[k / 4] : 1'b1;
            n_vec++; if (tx0 !== exp_tx)
                begin n_err++; $display("FAIL basic_tx k=%0d got=%b exp=%b", k, tx0, exp_tx); end
            n_vec++; if (done0 !== (k >= 40))
                begin n_err++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, done0, k >= 40); end
            @(negedge CLOCK_50);
        end
    endtask

    task automatic test_parity;
        logic [10:0] exp_odd;
        logic [11:0] exp_ev;
        logic        e_tx;
        exp_odd   = 11'b1_0_00000111_0;
        exp_ev    = 12'b11_1_00000111_0;
        clock_div = 16'd2; tx_data = 8'h07; rdy_odd = 1'b1; rdy_ev = 1'b1;
        @(negedge CLOCK_50);
        rdy_odd = 1'b0; rdy_ev = 1'b0;
        for (int k = 0; k <= 26; k++) begin
            e_tx = (k < 22) ? exp_odd[k / 2] : 1'b1;
            n_vec++; if (tx_odd !== e_tx)
                begin n_err++; $display("FAIL odd_tx k=%0d got=%b exp=%b", k, tx_odd, e_tx); end
            n_vec++; if (done_odd !== (k >= 22))
                begin n_err++; $display("FAIL odd_done k=%0d got=%b exp=%b", k, done_odd, k >= 22); end
            e_tx = (k < 24) ? exp_ev[k / 2] : 1'b1;
            n_vec++; if (tx_ev !== e_tx)
                begin n_err++; $display("FAIL even_tx k=%0d got=%b exp=%b", k, tx_ev, e_tx); end
            n_vec++; if (done_ev !== (k >= 24))
                begin n_err++; $display("FAIL even_done k=%0d got=%b exp=%b", k, done_ev, k >= 24); end
            @(negedge CLOCK_50);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] exp_a, exp_b;
        logic       e_tx;
        exp_a     = 10'b1_00111100_0;
        exp_b     = 10'b1_11000011_0;
        clock_div = 16'd2; tx_data = 8'h3C; rdy0 = 1'b1;
        @(negedge CLOCK_50);
        rdy0 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            n_vec++; if (tx0 !== exp_a[k / 2] || done0 !== 1'b0)
                begin n_err++; $display("FAIL b2b_a k=%0d got=%b%b exp=%b0", k, tx0, done0, exp_a[k / 2]); end
            // Raise lands on the completing edge and is then held high.
            if (k == 19) rdy0 = 1'b1;
            @(negedge CLOCK_50);
        end
        for (int j = 0; j < 10; j++) begin
            n_vec++; if (tx0 !== 1'b1 || done0 !== 1'b1)
                begin n_err++; $display("FAIL b2b_held j=%0d got=%b%b exp=11", j, tx0, done0); end
            @(negedge CLOCK_50);
        end
        rdy0 = 1'b0;
        @(negedge CLOCK_50);
        rdy0 = 1'b1; tx_data = 8'hC3;
        @(negedge CLOCK_50);
        for (int k = 0; k <= 22; k++) begin
            e_tx = (k < 20) ? exp_b[k / 2] : 1'b1;
            n_vec++; if (tx0 !== e_tx || done0 !== (k >= 20))
                begin n_err++; $display("FAIL b2b_b k=%0d got=%b%b exp=%b%b", k, tx0, done0, e_tx, k >= 20); end
            @(negedge CLOCK_50);
        end
        rdy0 = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic test_busy_ignore;
        logic [9:0] exp_bits;
        logic       e_tx;
        exp_bits  = 10'b1_10100011_0;
        clock_div = 16'd4; tx_data = 8'hA3; rdy0 = 1'b1;
        @(negedge CLOCK_50);
        rdy0 = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (k == 10) begin rdy0 = 1'b1; tx_data = 8'hFF; clock_div = 16'd9; end
            if (k == 11) rdy0 = 1'b0;
            e_tx = (k < 40) ? exp_bits[k / 4] : 1'b1;
            n_vec++; if (tx0 !== e_tx || done0 !== (k >= 40))
                begin n_err++; $display("FAIL busy k=%0d got=%b%b exp=%b%b", k, tx0, done0, e_tx, k >= 40); end
            @(negedge CLOCK_50);
        end
    endtask

    task automatic test_reset_abort;
        logic [9:0] exp_bits;
        logic       e_tx;
        exp_bits  = 10'b1_01000001_0;
        clock_div = 16'd4; tx_data = 8'hF0; rdy0 = 1'b1;
        @(negedge CLOCK_50);
        rdy0 = 1'b0;
        repeat (17) @(negedge CLOCK_50);
        n_vec++; if (tx0 !== 1'b0 || done0 !== 1'b0)
            begin n_err++; $display("FAIL abort_pre got=%b%b exp=00", tx0, done0); end
        #2 reset = 1'b0;
        #1;
        n_vec++; if (tx0 !== 1'b1 || done0 !== 1'b1)
            begin n_err++; $display("FAIL abort_async got=%b%b exp=11", tx0, done0); end
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        n_vec++; if (tx0 !== 1'b1 || done0 !== 1'b1)
            begin n_err++; $display("FAIL abort_release got=%b%b exp=11", tx0, done0); end
        tx_data = 8'h41; rdy0 = 1'b1;
        @(negedge CLOCK_50);
        rdy0 = 1'b0;
        for (int k = 0; k <= 43; k++) begin
            e_tx = (k < 40) ? exp_bits[k / 4] : 1'b1;
            n_vec++; if (tx0 !== e_tx || done0 !== (k >= 40))
                begin n_err++; $display("FAIL abort_frame k=%0d got=%b%b exp=%b%b", k, tx0, done0, e_tx, k >= 40); end
            @(negedge CLOCK_50);
        end
    endtask

    task automatic test_sequencer;
        logic [7:0] rom [3];
        int         cnt;
        rom       = '{8'h48, 8'h69, 8'h00};
        rx_en     = 1'b1;
        clock_div = BAUD_230400_DIV;
        @(negedge CLOCK_50);
        for (int i = 0; i < 3; i++) begin
            cnt = 0;
            while (done0 !== 1'b1 && cnt < 5000) begin cnt++; @(negedge CLOCK_50); end
            n_vec++; if (done0 !== 1'b1)
                begin n_err++; $display("FAIL seq_wait_idle i=%0d got=%b exp=1", i, done0); end
            tx_data = rom[i]; rdy0 = 1'b1;
            @(negedge CLOCK_50);
            rdy0 = 1'b0;
            cnt = 0;
            while (done0 === 1'b0 && cnt < 3000) begin cnt++; @(negedge CLOCK_50); end
            n_vec++; if (cnt != 2170)
                begin n_err++; $display("FAIL seq_frame_len i=%0d got=%0d exp=2170", i, cnt); end
        end
        repeat (3000) @(negedge CLOCK_50);
        n_vec++; if (rx_q.size() != 3)
            begin n_err++; $display("FAIL seq_frame_count got=%0d exp=3", rx_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= rx_q.size()) begin
                n_err++; $display("FAIL seq_byte i=%0d got=none exp=%h", i, rom[i]);
            end else if (rx_q[i] !== rom[i]) begin
                n_err++; $display("FAIL seq_byte i=%0d got=%h exp=%h", i, rx_q[i], rom[i]);
            end
        end
        n_vec++; if (rx_frame_err != 0)
            begin n_err++; $display("FAIL seq_framing got=%0d exp=0", rx_frame_err); end
        rx_en = 1'b0;
    endtask

    initial begin
        CLOCK_50 = 1'b0; reset = 1'b0; clock_div = 16'd4; tx_data = 8'h00;
        rdy0 = 1'b0; rdy_odd = 1'b0; rdy_ev = 1'b0;
        rx_en = 1'b0; rx_byte = 8'h00; rx_frame_err = 0;
        n_vec = 0; n_err = 0;
        test_reset;
        test_basic;
        test_parity;
        test_back_to_back;
        test_busy_ignore;
        test_reset_abort;
        test_sequencer;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
